io_sevenseg: RTL and testbench



---
 rtl/io_pkg.sv | 29 ++
 rtl/hex7seg.sv | 12 +
 rtl/io_sevenseg.sv | 103 ++++++++++
 tb/tb_io_sevenseg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for memory-mapped I/O peripherals: seven-segment display
// addresses, control bit positions and active-low segment patterns.
`timescale 1ns/1ps
package io_pkg;

    localparam logic [31:0] IO_SEVENSEG_BASE = 32'h0000_0100;

    localparam logic [31:0] OFS_VALUE = 32'd0;
    localparam logic [31:0] OFS_CTRL  = 32'd4;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_DP_LSB = 4;
    localparam logic [7:0] CTRL_RESET = 8'h01;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_BLANK  = 4'hF;

    // Active-low {g,f,e,d,c,b,a}, indexed by hex digit
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        REG_VALUE = 1'b0,
        REG_CTRL  = 1'b1
    } sevenseg_reg_e;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
`timescale 1ns/1ps
module hex7seg
    import io_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[hex];

endmodule

// File: rtl/io_sevenseg.sv
// Memory-mapped seven-segment display: VALUE/CTRL register pair on the data
// bus, multiplexed onto a four-digit common-anode display.
`timescale 1ns/1ps
module io_sevenseg
    import io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = IO_SEVENSEG_BASE,
    parameter int          REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic        hit,
    output logic [31:0] rd,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       dig;
    logic [15:0]      value_q;
    logic [7:0]       ctrl_q;
    logic             wr_en;
    logic             cnt_tc;
    sevenseg_reg_e    reg_sel;
    logic [3:0]       nibble;
    logic [6:0]       seg_dec;
    logic [3:0]       dp_mask;
    logic             unused_bits;

    assign hit     = (a[31:3] == BASE_ADDR[31:3]);
    assign reg_sel = (a[2] == OFS_CTRL[2]) ? REG_CTRL : REG_VALUE;
    assign wr_en   = cpu_en & we & hit;
    assign cnt_tc  = (cnt == CNT_TC);

    // Byte lanes below the word and unused store bits are deliberately dropped
    assign unused_bits = ^{a[1:0], wd[31:16], wd[3:1]};

    always_comb begin
        rd = '0;
        if (hit) begin
            case (reg_sel)
                REG_VALUE: rd = {16'b0, value_q};
                REG_CTRL:  rd = {24'b0, ctrl_q};
                default:   rd = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            dig <= 2'd0;
        end else if (cnt_tc) begin
            cnt <= '0;
            dig <= dig + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 16'h0000;
            ctrl_q  <= CTRL_RESET;
        end else if (wr_en) begin
            if (reg_sel == REG_CTRL) begin
                ctrl_q <= {wd[7:4], 3'b000, wd[0]};
            end else begin
                value_q <= wd[15:0];
            end
        end
    end

    assign nibble  = value_q[4*dig +: 4];
    assign dp_mask = ctrl_q[CTRL_DP_LSB +: 4];

    hex7seg u_hex7seg (
        .hex (nibble),
        .seg (seg_dec)
    );

    // Outputs are registered from the pre-edge VALUE/CTRL/dig
    always_ff @(posedge clk) begin
        if (reset || !ctrl_q[CTRL_EN_BIT]) begin
            an  <= AN_BLANK;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << dig);
            seg <= seg_dec;
            dp  <= ~dp_mask[dig];
        end
    end

endmodule

// File: tb/tb_io_sevenseg.sv
// Directed self-checking bench for io_sevenseg with a short refresh period.
`timescale 1ns/1ps
module tb_io_sevenseg;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          DIV  = 4;

    localparam logic [6:0] HEX_EXP [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        hit;
    logic [31:0] rd;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;
    logic [15:0] value_m;
    logic [7:0]  ctrl_m;

    always #5 clk = ~clk;

    io_sevenseg #(
        .BASE_ADDR   (BASE),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cpu_en (cpu_en),
        .we     (we),
        .a      (a),
        .wd     (wd),
        .hit    (hit),
        .rd     (rd),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // k = edges since reset was released
    task automatic tick();
        @(posedge clk);
        if (reset) k = 0;
        else       k++;
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        a      = addr;
        wd     = data;
        cpu_en = 1'b1;
        we     = 1'b1;
        tick();
        cpu_en = 1'b0;
        we     = 1'b0;
    endtask

    // Display after edge k reflects the digit selected before that edge
    task automatic check_disp(input string tag);
        int d;
        logic [3:0] nib;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        d   = ((k - 1) / DIV) % 4;
        nib = value_m[4*d +: 4];
        if (ctrl_m[0]) begin
            exp_an  = ~(4'b0001 << d);
            exp_seg = HEX_EXP[nib];
            exp_dp  = ~ctrl_m[4 + d];
        end else begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end
        chk({tag, "_an"},  {28'b0, an},  {28'b0, exp_an});
        chk({tag, "_seg"}, {25'b0, seg}, {25'b0, exp_seg});
        chk({tag, "_dp"},  {31'b0, dp},  {31'b0, exp_dp});
    endtask

    initial begin
        reset  = 1'b1;
        cpu_en = 1'b0;
        we     = 1'b0;
        a      = 32'h0;
        wd     = 32'h0;
        value_m = 16'h0000;
        ctrl_m  = 8'h01;

        tick();
        tick();
        chk("rst_an",  {28'b0, an},  32'hF);
        chk("rst_seg", {25'b0, seg}, 32'h7F);
        chk("rst_dp",  {31'b0, dp},  32'h1);
        reset = 1'b0;

        tick();
        chk("rel_an",  {28'b0, an},  32'hE);
        chk("rel_seg", {25'b0, seg}, 32'h40);
        chk("rel_dp",  {31'b0, dp},  32'h1);
        a = BASE;
        #1 chk("rst_hit_value", {31'b0, hit}, 32'h1);
        chk("rst_rd_value", rd, 32'h0);
        a = BASE + 4;
        #1 chk("rst_rd_ctrl", rd, 32'h1);

        store(BASE, 32'h0000_BEEF);
        value_m = 16'hBEEF;
        a = BASE;
        #1 chk("rd_beef", rd, 32'h0000_BEEF);
        tick();
        chk("beef_d0_seg", {25'b0, seg}, 32'h0E);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_disp("scan");
        end

        store(BASE + 4, 32'h0000_00A1);
        ctrl_m = 8'hA1;
        a = BASE + 4;
        #1 chk("rd_ctrl_a1", rd, 32'h0000_00A1);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_disp("dpmask");
        end

        store(BASE + 4, 32'hFFFF_FF0E);
        ctrl_m = 8'h00;
        a = BASE + 4;
        #1 chk("rd_ctrl_rsvd", rd, 32'h0);
        for (int i = 0; i < 9; i++) begin
            tick();
            check_disp("off");
        end
        store(BASE + 4, 32'h1);
        ctrl_m = 8'h01;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_disp("reon");
        end

        a      = BASE;
        wd     = 32'h0000_1111;
        we     = 1'b1;
        cpu_en = 1'b0;
        tick();
        we = 1'b0;
        #1 chk("gate_cpu_en", rd, 32'h0000_BEEF);
        a = BASE + 8;
        #1 chk("miss_hit", {31'b0, hit}, 32'h0);
        chk("miss_rd", rd, 32'h0);
        store(BASE + 8, 32'h0000_2222);
        a = 32'h0;
        #1 chk("zero_hit", {31'b0, hit}, 32'h0);
        a = BASE + 2;
        #1 chk("lowbits_rd", rd, 32'h0000_BEEF);
        a = BASE + 7;
        #1 chk("lowbits_ctrl", rd, 32'h1);

        // Land a write on the edge where dig advances 0 -> 1
        while (((k + 1) % 16) != DIV) tick();
        store(BASE + 1, 32'h0000_1234);
        value_m = 16'h1234;
        tick();
        chk("sim_an",  {28'b0, an},  32'hD);
        chk("sim_seg", {25'b0, seg}, 32'h30);
        chk("sim_dp",  {31'b0, dp},  32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_disp("post_sim");
        end

        a      = BASE;
        wd     = 32'h0000_FFFF;
        cpu_en = 1'b1;
        we     = 1'b1;
        reset  = 1'b1;
        tick();
        cpu_en = 1'b0;
        we     = 1'b0;
        chk("rst_mid_an", {28'b0, an}, 32'hF);
        reset = 1'b0;
        value_m = 16'h0000;
        ctrl_m  = 8'h01;
        tick();
        a = BASE;
        #1 chk("rst_wr_value", rd, 32'h0);
        a = BASE + 4;
        #1 chk("rst_wr_ctrl", rd, 32'h1);
        chk("rst_wr_an",  {28'b0, an},  32'hE);
        chk("rst_wr_seg", {25'b0, seg}, 32'h40);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_disp("after_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
